rf_ctrl: RTL and testbench

Request sequencer sitting directly upstream of the 16x8 register file (`RF`): accepts one command at a time over a valid/ready port, drives the RF `wren`/`rden`/`address`/`wrdata` pins with correct cycle timing, captures `rddata`, and returns a one-cycle response. Supports write, read, read-add-writeback (accumulate) and a multi-cycle clear-all sweep, so client logic never touches RF strobes directly.

---
 rtl/rf_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_rf_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl.sv
// rf_ctrl: single-command sequencer in front of a WIDTH x DEPTH register file.
// Owns the RF strobes so clients only see a valid/ready request and a
// one-cycle response pulse. All outputs except req_ready are registered.
module rf_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   // request port
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [AW-1:0]    req_addr,
   input  logic [WIDTH-1:0] req_data,
   // response port
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_ovf,
   output logic             resp_err,
   // register file pins
   output logic             rf_wren,
   output logic             rf_rden,
   output logic [AW-1:0]    rf_address,
   output logic [WIDTH-1:0] rf_wrdata,
   input  logic [WIDTH-1:0] rf_rddata
);

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD      = 3'd2,
      S_RD_WAIT = 3'd3,
      S_WB      = 3'd4,
      S_CLR     = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic             rf_wren_q, rf_wren_d;
   logic             rf_rden_q, rf_rden_d;
   logic [AW-1:0]    rf_address_q, rf_address_d;
   logic [WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;

   logic             resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             resp_ovf_q, resp_ovf_d;
   logic             resp_err_q, resp_err_d;

   logic             addr_bad_c;
   logic             clr_last_c;
   logic [WIDTH:0]   acc_c;

   // Out-of-range check only matters when DEPTH is not a power of two.
   assign addr_bad_c = (32'(req_addr) >= 32'(DEPTH));
   assign clr_last_c = (cnt_q == AW'(DEPTH - 1));
   // Read-modify-write sum with carry, formed as the read data arrives.
   assign acc_c      = {1'b0, rf_rddata} + {1'b0, data_q};

   // Ready is gated by reset so nothing can be accepted while held in reset.
   assign req_ready  = ~rst & (state_q == S_IDLE);

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_ovf   = resp_ovf_q;
   assign resp_err   = resp_err_q;
   assign rf_wren    = rf_wren_q;
   assign rf_rden    = rf_rden_q;
   assign rf_address = rf_address_q;
   assign rf_wrdata  = rf_wrdata_q;

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         rf_wren_q    <= 1'b0;
         rf_rden_q    <= 1'b0;
         rf_address_q <= '0;
         rf_wrdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_ovf_q   <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         carry_q      <= carry_d;
         rf_wren_q    <= rf_wren_d;
         rf_rden_q    <= rf_rden_d;
         rf_address_q <= rf_address_d;
         rf_wrdata_q  <= rf_wrdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_ovf_q   <= resp_ovf_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Next state and next register values; strobes are set for the state
   // being entered so they are high exactly during that state.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      sum_d        = sum_q;
      carry_d      = carry_q;
      rf_wren_d    = 1'b0;
      rf_rden_d    = 1'b0;
      rf_address_d = rf_address_q;
      rf_wrdata_d  = rf_wrdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_ovf_d   = resp_ovf_q;
      resp_err_d   = resp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d   = req_op;
               addr_d = req_addr;
               data_d = req_data;
               if ((req_op != OP_CLR) && addr_bad_c) begin
                  // Reject without touching the RF; respond next cycle.
                  resp_valid_d = 1'b1;
                  resp_data_d  = '0;
                  resp_ovf_d   = 1'b0;
                  resp_err_d   = 1'b1;
               end else begin
                  unique case (req_op)
                     OP_WR: begin
                        state_d      = S_WR;
                        rf_wren_d    = 1'b1;
                        rf_address_d = req_addr;
                        rf_wrdata_d  = req_data;
                     end
                     OP_RD, OP_ADD: begin
                        state_d      = S_RD;
                        rf_rden_d    = 1'b1;
                        rf_address_d = req_addr;
                     end
                     default: begin
                        state_d      = S_CLR;
                        cnt_d        = '0;
                        rf_wren_d    = 1'b1;
                        rf_address_d = '0;
                        rf_wrdata_d  = '0;
                     end
                  endcase
               end
            end
         end

         S_WR: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b1;
            resp_data_d  = data_q;
            resp_ovf_d   = 1'b0;
            resp_err_d   = 1'b0;
         end

         S_RD: begin
            state_d = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (op_q == OP_ADD) begin
               state_d      = S_WB;
               sum_d        = acc_c[WIDTH-1:0];
               carry_d      = acc_c[WIDTH];
               rf_wren_d    = 1'b1;
               rf_address_d = addr_q;
               rf_wrdata_d  = acc_c[WIDTH-1:0];
            end else begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b1;
               resp_data_d  = rf_rddata;
               resp_ovf_d   = 1'b0;
               resp_err_d   = 1'b0;
            end
         end

         S_WB: begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b1;
            resp_data_d  = sum_q;
            resp_ovf_d   = carry_q;
            resp_err_d   = 1'b0;
         end

         S_CLR: begin
            if (clr_last_c) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b1;
               resp_data_d  = '0;
               resp_ovf_d   = 1'b0;
               resp_err_d   = 1'b0;
            end else begin
               cnt_d        = cnt_q + AW'(1);
               rf_wren_d    = 1'b1;
               rf_address_d = cnt_q + AW'(1);
               rf_wrdata_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rf_ctrl.sv
// Bench for rf_ctrl: two instances (DEPTH 8 and DEPTH 6), each driving its own
// behavioural register file, checked against a command-level reference model.
module tb_rf_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_data;
   logic          v8, v6;

   logic          ready8, rv8, ovf8, err8, wren8, rden8;
   logic [W-1:0]  rdata8, wrdata8, rddata8;
   logic [AW-1:0] addr8;
   logic          ready6, rv6, ovf6, err6, wren6, rden6;
   logic [W-1:0]  rdata6, wrdata6, rddata6;
   logic [AW-1:0] addr6;

   rf_ctrl #(.WIDTH(16), .DEPTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .req_valid(v8), .req_ready(ready8), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
      .resp_valid(rv8), .resp_data(rdata8), .resp_ovf(ovf8), .resp_err(err8),
      .rf_wren(wren8), .rf_rden(rden8), .rf_address(addr8), .rf_wrdata(wrdata8), .rf_rddata(rddata8)
   );

   rf_ctrl #(.WIDTH(16), .DEPTH(6)) u_dut6 (
      .clk(clk), .rst(rst),
      .req_valid(v6), .req_ready(ready6), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
      .resp_valid(rv6), .resp_data(rdata6), .resp_ovf(ovf6), .resp_err(err6),
      .rf_wren(wren6), .rf_rden(rden6), .rf_address(addr6), .rf_wrdata(wrdata6), .rf_rddata(rddata6)
   );

   // Behavioural register files: synchronous write, registered read.
   logic [W-1:0] mem8 [8];
   logic [W-1:0] mem6 [8];
   always @(posedge clk) begin
      if (wren8) mem8[addr8] <= wrdata8;
      if (rden8) rddata8 <= mem8[addr8];
   end
   always @(posedge clk) begin
      if (wren6) mem6[addr6] <= wrdata6;
      if (rden6) rddata6 <= mem6[addr6];
   end

   // Mid-cycle monitors: count strobes and responses, log write traffic.
   logic [AW-1:0] wa8 [64];
   logic [W-1:0]  wd8 [64];
   logic [AW-1:0] wa6 [64];
   logic [W-1:0]  wd6 [64];
   int wc8 = 0, rc8 = 0, vc8 = 0, wc6 = 0, rc6 = 0, vc6 = 0;
   bit both8 = 1'b0, both6 = 1'b0;
   always @(negedge clk) begin
      if (wren8) begin wa8[wc8 % 64] <= addr8; wd8[wc8 % 64] <= wrdata8; wc8 <= wc8 + 1; end
      if (rden8) rc8 <= rc8 + 1;
      if (rv8) vc8 <= vc8 + 1;
      if (wren8 && rden8) both8 <= 1'b1;
   end
   always @(negedge clk) begin
      if (wren6) begin wa6[wc6 % 64] <= addr6; wd6[wc6 % 64] <= wrdata6; wc6 <= wc6 + 1; end
      if (rden6) rc6 <= rc6 + 1;
      if (rv6) vc6 <= vc6 + 1;
      if (wren6 && rden6) both6 <= 1'b1;
   end

   // Selected-instance view used by the command task.
   bit sel6 = 1'b0;
   logic         m_ready, m_valid, m_ovf, m_err;
   logic [W-1:0] m_data;
   int           m_wc, m_rc;
   assign m_ready = sel6 ? ready6 : ready8;
   assign m_valid = sel6 ? rv6 : rv8;
   assign m_ovf   = sel6 ? ovf6 : ovf8;
   assign m_err   = sel6 ? err6 : err8;
   assign m_data  = sel6 ? rdata6 : rdata8;
   assign m_wc    = sel6 ? wc6 : wc8;
   assign m_rc    = sel6 ? rc6 : rc8;

   function automatic logic [AW-1:0] log_a(input int i);
      return sel6 ? wa6[i % 64] : wa8[i % 64];
   endfunction
   function automatic logic [W-1:0] log_d(input int i);
      return sel6 ? wd6[i % 64] : wd8[i % 64];
   endfunction
   function automatic logic [W-1:0] rf_at(input int i);
      return sel6 ? mem6[i] : mem8[i];
   endfunction

   // Reference model: RF contents as seen at command granularity.
   logic [W-1:0] ref_mem [2][8];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_mem(input string tag);
      bit ok;
      int d;
      ok = 1'b1;
      d  = sel6 ? 6 : 8;
      for (int i = 0; i < d; i++)
         if (rf_at(i) !== ref_mem[sel6][i]) ok = 1'b0;
      chk(tag, 64'(ok), 64'(1));
   endtask

   // One command end to end; b2b keeps req_valid high for the next call.
   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [W-1:0] data, input bit b2b);
      int d, s, n, lat, w0, r0, exp_lat, exp_nw, exp_nr;
      bit e, exp_ovf, ready_ok, log_ok;
      logic [W-1:0]  exp_data;
      logic [AW-1:0] ew_a [8];
      logic [W-1:0]  ew_d [8];
      d = sel6 ? 6 : 8;
      e = (op != 2'b11) && (int'(addr) >= d);
      exp_ovf = 1'b0; exp_nw = 0; exp_nr = 0; exp_data = '0;
      if (e) begin
         exp_lat = 1;
      end else begin
         case (op)
            2'b00: begin
               ref_mem[sel6][addr] = data;
               exp_data = data; exp_lat = 2; exp_nw = 1;
               ew_a[0] = addr; ew_d[0] = data;
            end
            2'b01: begin
               exp_data = ref_mem[sel6][addr]; exp_lat = 3; exp_nr = 1;
            end
            2'b10: begin
               s = int'(ref_mem[sel6][addr]) + int'(data);
               exp_data = 16'(s % 65536);
               exp_ovf  = (s >= 65536);
               ref_mem[sel6][addr] = exp_data;
               exp_lat = 4; exp_nr = 1; exp_nw = 1;
               ew_a[0] = addr; ew_d[0] = exp_data;
            end
            default: begin
               for (int k = 0; k < d; k++) begin
                  ref_mem[sel6][k] = '0;
                  ew_a[k] = 3'(k);
                  ew_d[k] = '0;
               end
               exp_lat = d + 1; exp_nw = d;
            end
         endcase
      end

      req_op = op; req_addr = addr; req_data = data;
      if (sel6) v6 = 1'b1; else v8 = 1'b1;
      n = 0;
      while (!m_ready && n < 20) begin step(); n++; end
      chk("ready_at_request", 64'(m_ready), 64'(1));
      step();
      if (!b2b) begin v8 = 1'b0; v6 = 1'b0; end
      w0 = m_wc; r0 = m_rc;
      lat = 1; ready_ok = 1'b1;
      while (!m_valid && lat < 20) begin
         if (m_ready) ready_ok = 1'b0;
         step();
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("resp_data", 64'(m_data), 64'(exp_data));
      chk("resp_ovf", 64'(m_ovf), 64'(exp_ovf));
      chk("resp_err", 64'(m_err), 64'(e));
      chk("ready_low_while_busy", 64'(ready_ok), 64'(1));
      chk("wren_cycles", 64'(m_wc - w0), 64'(exp_nw));
      chk("rden_cycles", 64'(m_rc - r0), 64'(exp_nr));
      log_ok = 1'b1;
      for (int k = 0; k < exp_nw; k++)
         if (log_a(w0 + k) !== ew_a[k] || log_d(w0 + k) !== ew_d[k]) log_ok = 1'b0;
      chk("write_trace", 64'(log_ok), 64'(1));
      chk_mem("rf_contents");
      if (!b2b) begin
         step();
         chk("resp_single_pulse", 64'(m_valid), 64'(0));
         chk("resp_data_held", 64'(m_data), 64'(exp_data));
      end
   endtask

   task automatic chk_outputs_zero8(input string tag);
      chk(tag, 64'({rv8, rdata8, ovf8, err8, wren8, rden8, addr8, wrdata8}), 64'(0));
   endtask

   logic [1:0]    r_op;
   logic [AW-1:0] r_addr;
   logic [W-1:0]  r_data;
   bit            r_b2b;
   int            vc_snap, sel_r;

   initial begin
      v8 = 1'b0; v6 = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero8("reset_outputs");
      chk("ready_in_reset", 64'(ready8), 64'(0));
      #2 rst = 1'b0;
      step();
      chk("ready_after_reset", 64'(ready8), 64'(1));
      chk_outputs_zero8("idle_outputs");

      // Directed scenarios on the DEPTH=8 instance.
      sel6 = 1'b0;
      do_cmd(2'b11, 3'd0, 16'h0000, 1'b0);
      do_cmd(2'b00, 3'd0, 16'h0032, 1'b0);
      do_cmd(2'b01, 3'd0, 16'h0000, 1'b0);
      do_cmd(2'b00, 3'd2, 16'h005D, 1'b1);
      do_cmd(2'b01, 3'd2, 16'h0000, 1'b0);
      do_cmd(2'b01, 3'd0, 16'h0000, 1'b0);
      do_cmd(2'b00, 3'd5, 16'hFFF0, 1'b0);
      do_cmd(2'b10, 3'd5, 16'h0020, 1'b0);
      do_cmd(2'b10, 3'd5, 16'h0001, 1'b0);
      for (int k = 0; k < 8; k++) do_cmd(2'b00, 3'(k), 16'($urandom_range(1, 16'hFFFF)), 1'b0);
      do_cmd(2'b11, 3'd0, 16'h0000, 1'b0);
      for (int k = 0; k < 8; k++) do_cmd(2'b01, 3'(k), 16'h0000, 1'b0);

      // DEPTH=6 instance: out-of-range addresses and normal traffic.
      sel6 = 1'b1;
      do_cmd(2'b11, 3'd0, 16'h0000, 1'b0);
      do_cmd(2'b01, 3'd7, 16'h0000, 1'b0);
      do_cmd(2'b00, 3'd6, 16'hBEEF, 1'b0);
      do_cmd(2'b00, 3'd5, 16'h1234, 1'b0);
      do_cmd(2'b01, 3'd5, 16'h0000, 1'b0);
      for (int i = 0; i < 40; i++) begin
         sel_r  = int'($urandom_range(0, 9));
         r_op   = (sel_r < 3) ? 2'b00 : (sel_r < 6) ? 2'b01 : (sel_r < 9) ? 2'b10 : 2'b11;
         r_addr = 3'($urandom_range(0, 7));
         r_data = 16'($urandom);
         r_b2b  = (i != 39) && ($urandom_range(0, 1) == 1);
         do_cmd(r_op, r_addr, r_data, r_b2b);
      end

      // Randomized traffic on the DEPTH=8 instance.
      sel6 = 1'b0;
      for (int i = 0; i < 120; i++) begin
         sel_r  = int'($urandom_range(0, 9));
         r_op   = (sel_r < 3) ? 2'b00 : (sel_r < 6) ? 2'b01 : (sel_r < 9) ? 2'b10 : 2'b11;
         r_addr = 3'($urandom_range(0, 7));
         r_data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF)) : 16'($urandom);
         r_b2b  = (i != 119) && ($urandom_range(0, 1) == 1);
         do_cmd(r_op, r_addr, r_data, r_b2b);
         if (!r_b2b) repeat ($urandom_range(0, 2)) step();
      end

      // Reset during RD_WAIT of a read.
      req_op = 2'b01; req_addr = 3'd4; v8 = 1'b1;
      step();
      v8 = 1'b0;
      step();
      vc_snap = vc8;
      #2 rst = 1'b1;
      #1;
      chk_outputs_zero8("reset_in_rd_wait");
      chk("ready_in_reset_rd", 64'(ready8), 64'(0));
      step(); step();
      #2 rst = 1'b0;
      step();
      chk("ready_after_rd_abort", 64'(ready8), 64'(1));
      chk("no_resp_after_rd_abort", 64'(vc8 - vc_snap), 64'(0));
      chk_mem("rf_after_rd_abort");

      // Reset during a clear sweep after three entries are zeroed.
      for (int k = 0; k < 8; k++) do_cmd(2'b00, 3'(k), 16'($urandom_range(1, 16'hFFFF)), 1'b0);
      req_op = 2'b11; req_addr = 3'd0; v8 = 1'b1;
      step();
      v8 = 1'b0;
      step(); step(); step();
      vc_snap = vc8;
      #2 rst = 1'b1;
      for (int k = 0; k < 3; k++) ref_mem[0][k] = '0;
      #1;
      chk_outputs_zero8("reset_in_clr");
      step();
      #2 rst = 1'b0;
      step();
      chk("ready_after_clr_abort", 64'(ready8), 64'(1));
      chk("no_resp_after_clr_abort", 64'(vc8 - vc_snap), 64'(0));
      chk_mem("rf_after_clr_abort");
      do_cmd(2'b01, 3'd2, 16'h0000, 1'b0);
      do_cmd(2'b01, 3'd3, 16'h0000, 1'b0);

      chk("no_wren_rden_overlap8", 64'(both8), 64'(0));
      chk("no_wren_rden_overlap6", 64'(both6), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
